// File: rtl/rr_arb_2to1_pkg.sv
// Shared definitions for the 2:1 round-robin packet arbiter and the
// downstream 2:1 select stage that consumes its sel output.
//   state_t : arbiter lock state
//   SEL_A   : select value that passes channel A
//   SEL_B   : select value that passes channel B
package rr_arb_2to1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rr_arb_2to1_pick2.sv
// Combinational round-robin pick between two requesters, used when the
// arbiter is not locked to a packet.
//   a_vld, b_vld : channel requests
//   last_served  : channel that completed the most recent packet (SEL_A/SEL_B)
//   grant_vld    : at least one channel is requesting
//   grant_sel    : winning channel (SEL_A/SEL_B); meaningful only with grant_vld
module rr_pick2
    import rr_arb_2to1_pkg::*;
(
    input  logic a_vld,
    input  logic b_vld,
    input  logic last_served,
    output logic grant_vld,
    output logic grant_sel
);

    always_comb begin
        grant_vld = a_vld || b_vld;
        grant_sel = SEL_A;
        if (a_vld && b_vld) begin
            // tie goes to the channel that did not finish the last packet
            grant_sel = (last_served == SEL_A) ? SEL_B : SEL_A;
        end else if (b_vld) begin
            grant_sel = SEL_B;
        end
    end

endmodule

// File: rtl/rr_arb_2to1.sv
// Two-channel round-robin packet arbiter feeding a 2:1 select stage.
// The grant is locked for a whole packet; the winning beat is registered
// together with its select value so data and sel stay aligned downstream.
//   clk_in, rst_in              : clock, synchronous active-high reset
//   a_* / b_*                   : input valid/ready streams with last flag
//   y_data_out/vld/last, y_rdy_in : one-entry registered output stream
//   sel_out                     : source of current y beat (0=A, 1=B)
//   busy_out                    : packet in progress or output occupied
//   a_pkt_cnt_out/b_pkt_cnt_out : wrapping completed-packet counters
//
// state  | meaning
// IDLE   | no packet in progress; next winner chosen by round-robin pick
// LOCK_A | mid-packet on A; only A may be accepted until its last beat
// LOCK_B | mid-packet on B; only B may be accepted until its last beat
module rr_arb_2to1
    import rr_arb_2to1_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] a_data_in,
    input  logic              a_vld_in,
    input  logic              a_last_in,
    output logic              a_rdy_out,
    input  logic [DATA_W-1:0] b_data_in,
    input  logic              b_vld_in,
    input  logic              b_last_in,
    output logic              b_rdy_out,
    output logic [DATA_W-1:0] y_data_out,
    output logic              y_vld_out,
    output logic              y_last_out,
    input  logic              y_rdy_in,
    output logic              sel_out,
    output logic              busy_out,
    output logic [CNT_W-1:0]  a_pkt_cnt_out,
    output logic [CNT_W-1:0]  b_pkt_cnt_out
);

    state_t state;
    logic   last_served;
    logic   out_free;
    logic   pick_vld;
    logic   pick_sel;
    logic   a_acc;
    logic   b_acc;

    rr_pick2 u_pick (
        .a_vld       (a_vld_in),
        .b_vld       (b_vld_in),
        .last_served (last_served),
        .grant_vld   (pick_vld),
        .grant_sel   (pick_sel)
    );

    assign out_free = !y_vld_out || y_rdy_in;

    // Gated by rst_in so nothing looks accepted while reset is applied.
    assign a_rdy_out = !rst_in && out_free &&
                       ((state == LOCK_A) ||
                        (state == IDLE && pick_vld && pick_sel == SEL_A));
    assign b_rdy_out = !rst_in && out_free &&
                       ((state == LOCK_B) ||
                        (state == IDLE && pick_vld && pick_sel == SEL_B));

    assign a_acc = a_rdy_out && a_vld_in;
    assign b_acc = b_rdy_out && b_vld_in;

    assign busy_out = !rst_in && ((state != IDLE) || y_vld_out);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            last_served   <= SEL_B;
            y_data_out    <= '0;
            y_vld_out     <= 1'b0;
            y_last_out    <= 1'b0;
            sel_out       <= SEL_A;
            a_pkt_cnt_out <= '0;
            b_pkt_cnt_out <= '0;
        end else if (a_acc) begin
            y_data_out <= a_data_in;
            y_last_out <= a_last_in;
            y_vld_out  <= 1'b1;
            sel_out    <= SEL_A;
            if (a_last_in) begin
                state         <= IDLE;
                last_served   <= SEL_A;
                a_pkt_cnt_out <= a_pkt_cnt_out + 1'b1;
            end else begin
                state <= LOCK_A;
            end
        end else if (b_acc) begin
            y_data_out <= b_data_in;
            y_last_out <= b_last_in;
            y_vld_out  <= 1'b1;
            sel_out    <= SEL_B;
            if (b_last_in) begin
                state         <= IDLE;
                last_served   <= SEL_B;
                b_pkt_cnt_out <= b_pkt_cnt_out + 1'b1;
            end else begin
                state <= LOCK_B;
            end
        end else if (out_free) begin
            // beat drained with nothing to replace it; payload regs hold
            y_vld_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_2to1.sv
module tb_rr_arb_2to1;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  a_data_in, b_data_in;
    logic        a_vld_in, a_last_in, b_vld_in, b_last_in;
    logic        a_rdy_out, b_rdy_out;
    logic [7:0]  y_data_out;
    logic        y_vld_out, y_last_out, y_rdy_in, sel_out, busy_out;
    logic [15:0] a_pkt_cnt_out, b_pkt_cnt_out;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arb_2to1 #(.DATA_W(8), .CNT_W(16)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .a_data_in     (a_data_in),
        .a_vld_in      (a_vld_in),
        .a_last_in     (a_last_in),
        .a_rdy_out     (a_rdy_out),
        .b_data_in     (b_data_in),
        .b_vld_in      (b_vld_in),
        .b_last_in     (b_last_in),
        .b_rdy_out     (b_rdy_out),
        .y_data_out    (y_data_out),
        .y_vld_out     (y_vld_out),
        .y_last_out    (y_last_out),
        .y_rdy_in      (y_rdy_in),
        .sel_out       (sel_out),
        .busy_out      (busy_out),
        .a_pkt_cnt_out (a_pkt_cnt_out),
        .b_pkt_cnt_out (b_pkt_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural reference: who owns the current packet (-1 none, 0 A, 1 B),
    // who finished the last packet, the single output slot and packet totals.
    int         owner;
    int         last_ch;
    bit         m_vld, m_last, m_sel;
    logic [7:0] m_data;
    int         m_cnt [2];
    bit         model_ok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int candidate();
        bit v [2];
        v[0] = a_vld_in;
        v[1] = b_vld_in;
        if (owner >= 0) return owner;
        if (v[0] && v[1]) return 1 - last_ch;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    function automatic bit slot_free();
        return !m_vld || y_rdy_in;
    endfunction

    task automatic model_compare();
        int c;
        bit ra, rb;
        c  = candidate();
        ra = !rst_in && slot_free() && c == 0;
        rb = !rst_in && slot_free() && c == 1;
        chk("a_rdy", a_rdy_out, ra);
        chk("b_rdy", b_rdy_out, rb);
        if (model_ok) begin
            chk("busy", busy_out, !rst_in && (owner >= 0 || m_vld));
            chk("y_vld", y_vld_out, m_vld);
            chk("y_data", y_data_out, m_data);
            chk("y_last", y_last_out, m_last);
            chk("sel", sel_out, m_sel);
            chk("a_cnt", a_pkt_cnt_out, m_cnt[0]);
            chk("b_cnt", b_pkt_cnt_out, m_cnt[1]);
        end
    endtask

    task automatic model_update();
        int c;
        bit         vl [2];
        bit         ls [2];
        logic [7:0] dt [2];
        vl[0] = a_vld_in;  vl[1] = b_vld_in;
        ls[0] = a_last_in; ls[1] = b_last_in;
        dt[0] = a_data_in; dt[1] = b_data_in;
        if (rst_in) begin
            owner = -1; last_ch = 1; m_vld = 0; m_last = 0; m_sel = 0;
            m_data = 0; m_cnt[0] = 0; m_cnt[1] = 0; model_ok = 1;
            return;
        end
        c = candidate();
        if (slot_free() && c >= 0 && vl[c]) begin
            m_vld = 1; m_data = dt[c]; m_last = ls[c]; m_sel = (c == 1);
            if (ls[c]) begin
                owner = -1; last_ch = c;
                m_cnt[c] = (m_cnt[c] + 1) % 65536;
            end else begin
                owner = c;
            end
        end else if (slot_free()) begin
            m_vld = 0;
        end
    endtask

    // Inputs are set just after a rising edge; one step compares at the
    // falling edge, advances the model at the rising edge, then settles.
    task automatic step();
        @(negedge clk_in);
        model_compare();
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        a_vld_in = 0; a_last_in = 0; a_data_in = 0;
        b_vld_in = 0; b_last_in = 0; b_data_in = 0;
    endtask

    task automatic do_reset();
        rst_in = 1;
        step();
        #1;
        chk("rst_a_rdy", a_rdy_out, 0);
        chk("rst_busy", busy_out, 0);
        step();
        rst_in = 0;
    endtask

    initial begin
        rst_in = 1; y_rdy_in = 1;
        idle_inputs();
        owner = -1; last_ch = 1;
        do_reset();
        chk("post_rst_vld", y_vld_out, 0);
        chk("post_rst_cnt", a_pkt_cnt_out, 0);
        chk("post_rst_data", y_data_out, 0);

        // single-beat A
        a_vld_in = 1; a_last_in = 1; a_data_in = 8'h11;
        step();
        chk("t1_data", y_data_out, 8'h11);
        chk("t1_sel", sel_out, 0);
        chk("t1_last", y_last_out, 1);
        chk("t1_acnt", a_pkt_cnt_out, 1);

        // continuous ties alternate; A just finished so B leads here
        b_vld_in = 1; b_last_in = 1; b_data_in = 8'hB0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("alt_sel", sel_out, (i % 2 == 0) ? 1 : 0);
            chk("alt_vld", y_vld_out, 1);
        end
        // last served is B now, so A wins the next tie
        a_last_in = 0; a_data_in = 8'h01;
        step();
        chk("pkt_b1", y_data_out, 8'h01);
        a_data_in = 8'h02;
        #1 chk("pkt_brdy_lock", b_rdy_out, 0);
        step();
        chk("pkt_b2", y_data_out, 8'h02);
        a_data_in = 8'h03; a_last_in = 1;
        #1 chk("pkt_brdy_lock2", b_rdy_out, 0);
        step();
        chk("pkt_b3", y_data_out, 8'h03);
        chk("pkt_b3_sel", sel_out, 0);
        a_vld_in = 0;
        step();
        chk("pkt_then_b", y_data_out, 8'hB0);
        chk("pkt_then_b_sel", sel_out, 1);

        // stall mid-packet
        b_vld_in = 0;
        a_vld_in = 1; a_last_in = 0; a_data_in = 8'h21;
        step();
        y_rdy_in = 0; a_data_in = 8'h22; a_last_in = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("stall_ardy", a_rdy_out, 0);
            step();
            chk("stall_data", y_data_out, 8'h21);
            chk("stall_sel", sel_out, 0);
        end
        y_rdy_in = 1;
        step();
        chk("stall_resume", y_data_out, 8'h22);
        chk("stall_resume_last", y_last_out, 1);
        a_vld_in = 0;
        step();
        chk("stall_drain", y_vld_out, 0);

        // reset while locked on B with a beat pending
        b_vld_in = 1; b_last_in = 0; b_data_in = 8'h31;
        step();
        y_rdy_in = 0;
        step();
        rst_in = 1;
        step();
        rst_in = 0; y_rdy_in = 1;
        chk("rst_mid_vld", y_vld_out, 0);
        chk("rst_mid_busy", busy_out, 0);
        chk("rst_mid_cnt", a_pkt_cnt_out + b_pkt_cnt_out, 0);
        a_vld_in = 1; a_last_in = 1; a_data_in = 8'h41;
        b_last_in = 1;
        step();
        chk("rst_mid_tie", sel_out, 0);
        idle_inputs();
        step();

        // counter wrap
        do_reset();
        a_vld_in = 1; a_last_in = 1; a_data_in = 8'h55;
        for (int i = 0; i < 65535; i++) step();
        chk("wrap_max", a_pkt_cnt_out, 16'hFFFF);
        step();
        chk("wrap_zero", a_pkt_cnt_out, 0);
        idle_inputs();
        step();

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_in    = ($urandom_range(0, 99) == 0);
            a_vld_in  = ($urandom_range(0, 9) < 7);
            b_vld_in  = ($urandom_range(0, 9) < 7);
            a_last_in = ($urandom_range(0, 9) < 4);
            b_last_in = ($urandom_range(0, 9) < 4);
            a_data_in = 8'($urandom);
            b_data_in = 8'($urandom);
            y_rdy_in  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
